hazard_ctrl: RTL and testbench

//  Sequences IF/ID: drives its hold (HD_i) and flush (Flush1_i/Flush2_i) inputs, PC write enable, ID/EX bubble.

---
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// IF/ID hazard-control signal bundle: ID/EX hazard inputs in, pipeline sequencing outputs out.
// master drives the ID/EX status side; slave is the hazard controller.
interface hazard_ctrl_if;
  logic [4:0]  id_rs_i;
  logic [4:0]  id_rt_i;
  logic        id_uses_rt_i;
  logic        id_is_branch_i;
  logic        ex_memread_i;
  logic        ex_regwrite_i;
  logic [4:0]  ex_rd_i;
  logic        branch_taken_i;
  logic        jump_i;
  logic        mem_busy_i;
  logic        pc_write_o;
  logic        ifid_hold_o;
  logic        ifid_flush1_o;
  logic        ifid_flush2_o;
  logic        idex_bubble_o;
  logic        freeze_o;
  logic        stall_err_o;
  logic [31:0] stall_cycles_o;
  logic [31:0] flush_count_o;

  modport master (
    output id_rs_i, id_rt_i, id_uses_rt_i, id_is_branch_i, ex_memread_i, ex_regwrite_i,
           ex_rd_i, branch_taken_i, jump_i, mem_busy_i,
    input  pc_write_o, ifid_hold_o, ifid_flush1_o, ifid_flush2_o, idex_bubble_o, freeze_o,
           stall_err_o, stall_cycles_o, flush_count_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rt_i, id_is_branch_i, ex_memread_i, ex_regwrite_i,
           ex_rd_i, branch_taken_i, jump_i, mem_busy_i,
    output pc_write_o, ifid_hold_o, ifid_flush1_o, ifid_flush2_o, idex_bubble_o, freeze_o,
           stall_err_o, stall_cycles_o, flush_count_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// IF/ID hazard controller: load-use / branch-operand stalls, memory-wait freeze with timeout.
// Define HAZARD_PERF_CNT_EN to build the stall-cycle and flush performance counters.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StRun, StStall, StMemWait} state_e;

  state_e     state_q, state_d;
  logic [1:0] stall_cnt_q, stall_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_now;

  logic match_rs, match_rt, match_any, haz, haz_two, in_stall;
  logic pc_write, hold, flush1, flush2, bubble, freeze;

  always_comb begin
    match_rs  = (bus.id_rs_i != 5'd0) && (bus.id_rs_i == bus.ex_rd_i) && bus.ex_regwrite_i;
    match_rt  = bus.id_uses_rt_i && (bus.id_rt_i != 5'd0) && (bus.id_rt_i == bus.ex_rd_i) &&
                bus.ex_regwrite_i;
    match_any = match_rs || match_rt;
    haz       = match_any && (bus.ex_memread_i || bus.id_is_branch_i);
    haz_two   = match_any && bus.ex_memread_i && bus.id_is_branch_i;
    // A retained stall resumes in the very cycle the memory wait ends
    in_stall  = (state_q == StStall) || ((state_q == StMemWait) && (stall_cnt_q != 2'd0));
  end

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    wait_cnt_d  = 8'd0;
    pc_write    = 1'b0;
    hold        = 1'b0;
    flush1      = 1'b0;
    flush2      = 1'b0;
    bubble      = 1'b0;
    freeze      = 1'b0;
    if (bus.mem_busy_i) begin
      freeze  = 1'b1;
      hold    = 1'b1;
      state_d = StMemWait;
      if (state_q == StMemWait) begin
        wait_cnt_d = (wait_cnt_q == 8'hff) ? 8'hff : wait_cnt_q + 8'd1;
      end else begin
        wait_cnt_d = 8'd1;
      end
    end else if (in_stall) begin
      hold        = 1'b1;
      bubble      = 1'b1;
      stall_cnt_d = stall_cnt_q - 2'd1;
      state_d     = (stall_cnt_d == 2'd0) ? StRun : StStall;
    end else if (haz) begin
      hold   = 1'b1;
      bubble = 1'b1;
      if (haz_two) begin
        stall_cnt_d = 2'd1;
        state_d     = StStall;
      end else begin
        state_d = StRun;
      end
    end else begin
      pc_write = 1'b1;
      state_d  = StRun;
      if (bus.jump_i) begin
        flush2 = 1'b1;
      end else if (bus.branch_taken_i) begin
        flush1 = 1'b1;
      end
    end
    // wait_cnt_d counts busy cycles including the current one
    err_now = bus.mem_busy_i && (32'(wait_cnt_d) >= MEM_TIMEOUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      stall_cnt_q <= 2'd0;
      wait_cnt_q  <= 8'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_q | err_now;
    end
  end

  assign bus.pc_write_o    = pc_write & ~rst;
  assign bus.ifid_hold_o   = hold & ~rst;
  assign bus.ifid_flush1_o = flush1 & ~rst;
  assign bus.ifid_flush2_o = flush2 & ~rst;
  assign bus.idex_bubble_o = bubble & ~rst;
  assign bus.freeze_o      = freeze & ~rst;
  assign bus.stall_err_o   = (err_q | err_now) & ~rst;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      if (!pc_write) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (flush1 || flush2) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign bus.stall_cycles_o = stall_cycles_q;
  assign bus.flush_count_o  = flush_count_q;
`else
  assign bus.stall_cycles_o = 32'd0;
  assign bus.flush_count_o  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl: a rule-level model is checked against the DUT every cycle,
// with directed sequences pinning the model to hand-computed control words.
module tb_hazard_ctrl;
  localparam int unsigned Timeout = 4;

  logic clk;
  logic rst;
  hazard_ctrl_if bus ();

  hazard_ctrl #(.MEM_TIMEOUT(Timeout)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: pending extra stall cycles, current busy run length, sticky error, counters
  int          m_pend     = 0;
  int          m_busy_run = 0;
  bit          m_err      = 1'b0;
  logic [31:0] m_stalls   = 32'd0;
  logic [31:0] m_flushes  = 32'd0;

  // {pc_write, hold, flush1, flush2, bubble, freeze, err}
  function automatic logic [6:0] dut_ctrl();
    return {bus.pc_write_o, bus.ifid_hold_o, bus.ifid_flush1_o, bus.ifid_flush2_o,
            bus.idex_bubble_o, bus.freeze_o, bus.stall_err_o};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic lit(input string name, input logic [6:0] exp);
    check(name, {25'd0, dut_ctrl()}, {25'd0, exp});
  endtask

  function automatic bit reg_match(input logic [4:0] r);
    return (r != 5'd0) && (r == bus.ex_rd_i) && bus.ex_regwrite_i;
  endfunction

  always @(negedge clk) begin
    logic [6:0] e;
    bit         m_any, haz, two;
    m_any = reg_match(bus.id_rs_i) || (bus.id_uses_rt_i && reg_match(bus.id_rt_i));
    haz   = m_any && (bus.ex_memread_i || bus.id_is_branch_i);
    two   = m_any && bus.ex_memread_i && bus.id_is_branch_i;
    e     = 7'd0;
    if (!rst) begin
      if (bus.mem_busy_i) begin
        e = {6'b010001, m_err || (m_busy_run + 1 >= int'(Timeout))};
      end else if (m_pend > 0 || haz) begin
        e = {6'b010010, m_err};
      end else begin
        e = {1'b1, 1'b0, bus.branch_taken_i && !bus.jump_i, bus.jump_i, 2'b00, m_err};
      end
    end
    check("ctrl", {25'd0, dut_ctrl()}, {25'd0, e});
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cycles", bus.stall_cycles_o, m_stalls);
    check("flush_count", bus.flush_count_o, m_flushes);
`else
    check("stall_cycles", bus.stall_cycles_o, 32'd0);
    check("flush_count", bus.flush_count_o, 32'd0);
`endif
    if (rst) begin
      m_pend = 0; m_busy_run = 0; m_err = 1'b0; m_stalls = 32'd0; m_flushes = 32'd0;
    end else begin
      if (!e[6]) m_stalls = m_stalls + 32'd1;
      if (e[4] || e[3]) m_flushes = m_flushes + 32'd1;
      m_err = e[0];
      if (bus.mem_busy_i) begin
        m_busy_run++;
      end else begin
        m_busy_run = 0;
        if (m_pend > 0) m_pend--;
        else if (two) m_pend = 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.id_rs_i = 5'd0; bus.id_rt_i = 5'd0; bus.id_uses_rt_i = 1'b0; bus.id_is_branch_i = 1'b0;
    bus.ex_memread_i = 1'b0; bus.ex_regwrite_i = 1'b0; bus.ex_rd_i = 5'd0;
    bus.branch_taken_i = 1'b0; bus.jump_i = 1'b0; bus.mem_busy_i = 1'b0;
  endtask

  task automatic load_hazard(input logic [4:0] r, input logic br);
    clear_in();
    bus.ex_memread_i = 1'b1; bus.ex_regwrite_i = 1'b1; bus.ex_rd_i = r;
    bus.id_rs_i = r; bus.id_is_branch_i = br;
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    #3;
    lit("reset_ctrl", 7'b0000000);
    check("reset_stalls", bus.stall_cycles_o, 32'd0);
    cyc(); cyc();
    rst = 1'b0;
    #2 lit("run_idle", 7'b1000000);

    // 1: lw $2 / add $2 -> single stall
    cyc(); load_hazard(5'd2, 1'b0);
    #2 lit("lu_stall", 7'b0100100);
    cyc(); clear_in();
    #2 lit("lu_resume", 7'b1000000);

    // 2: lw $3 / beq $3 -> two stalls, then taken branch flush
    cyc(); load_hazard(5'd3, 1'b1);
    #2 lit("lb_stall1", 7'b0100100);
    cyc(); clear_in(); bus.id_rs_i = 5'd3; bus.id_is_branch_i = 1'b1;
    #2 lit("lb_stall2", 7'b0100100);
    cyc(); bus.branch_taken_i = 1'b1;
    #2 lit("lb_flush1", 7'b1010000);
    cyc(); clear_in();
    #2 lit("lb_after", 7'b1000000);

    // 3: jump wins over taken branch
    cyc(); bus.jump_i = 1'b1; bus.branch_taken_i = 1'b1;
    #2 lit("jump_flush2", 7'b1001000);

    // 4: busy 5 cycles while one stall is pending; timeout hit on the 4th busy cycle
    cyc(); load_hazard(5'd5, 1'b1);
    #2 lit("mw_stall", 7'b0100100);
    for (int k = 1; k <= 5; k++) begin
      cyc(); clear_in(); bus.mem_busy_i = 1'b1;
      #2 lit("mw_freeze", (k >= 4) ? 7'b0100011 : 7'b0100010);
    end
    cyc(); clear_in();
    #2 lit("mw_resume_stall", 7'b0100101);
    cyc();
    #2 lit("mw_run_err", 7'b1000001);

    // 6: async reset in the middle of a memory wait
    cyc(); bus.mem_busy_i = 1'b1;
    cyc();
    cyc(); rst = 1'b1;
    #1 lit("rst_async", 7'b0000000);
    check("rst_flushes", bus.flush_count_o, 32'd0);
    cyc(); rst = 1'b0; clear_in();
    #2 lit("rst_release", 7'b1000000);

    // 5: busy 6 cycles, error from the 4th and sticky afterwards
    for (int k = 1; k <= 6; k++) begin
      cyc(); bus.mem_busy_i = 1'b1;
      #2 lit("to_busy", (k >= 4) ? 7'b0100011 : 7'b0100010);
    end
    cyc(); bus.mem_busy_i = 1'b0;
    #2 lit("to_sticky", 7'b1000001);

    // Random phase
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst = ($urandom_range(0, 79) == 0);
      bus.id_rs_i        = 5'($urandom_range(0, 3));
      bus.id_rt_i        = 5'($urandom_range(0, 3));
      bus.ex_rd_i        = 5'($urandom_range(0, 3));
      bus.id_uses_rt_i   = 1'($urandom_range(0, 1));
      bus.id_is_branch_i = ($urandom_range(0, 2) == 0);
      bus.ex_memread_i   = 1'($urandom_range(0, 1));
      bus.ex_regwrite_i  = ($urandom_range(0, 3) != 0);
      bus.branch_taken_i = ($urandom_range(0, 3) == 0);
      bus.jump_i         = ($urandom_range(0, 4) == 0);
      bus.mem_busy_i     = bus.mem_busy_i ? ($urandom_range(0, 3) != 0)
                                          : ($urandom_range(0, 9) == 0);
    end
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
